// File: rtl/keypad_emulator.sv
// Keypad emulator: queues digits from a valid/ready port and plays each one back
// onto the active-low row lines as a whole-frame press followed by a whole-frame release.
module keypad_emulator #(
  parameter int DEPTH          = 4,
  parameter int PRESS_FRAMES   = 2,
  parameter int RELEASE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] column,
  output logic [3:0] row,
  input  logic [3:0] in_digit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       pressed,
  output logic       bad_code,
  output logic       done
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXF = (PRESS_FRAMES > RELEASE_FRAMES) ? PRESS_FRAMES : RELEASE_FRAMES;
  localparam int CW   = (MAXF > 1) ? $clog2(MAXF) : 1;

  localparam logic [AW:0]   FIFO_FULL    = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_FRAMES - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    PRESS,
    RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      key_q, key_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [3:0]      mem_q [DEPTH];
  logic [3:0]      mem_d [DEPTH];
  logic [3:0]      col_prev_q, col_prev_d;
  logic            done_q, done_d;
  logic            bad_code_q, bad_code_d;

  logic [7:0]      in_info;
  logic [7:0]      key_info;
  logic            in_mapped;
  logic            push;
  logic            push_store;
  logic            pop;
  logic            frame_end;

  // Returns {column strobe, row pattern}; unmapped codes come back as all ones.
  function automatic logic [7:0] key_lookup(input logic [3:0] code);
    logic [7:0] info;
    case (code)
      4'h1:    info = {4'b1110, 4'b1110};
      4'h4:    info = {4'b1110, 4'b1101};
      4'h7:    info = {4'b1110, 4'b1011};
      4'h0:    info = {4'b1110, 4'b0111};
      4'h2:    info = {4'b1101, 4'b1110};
      4'h5:    info = {4'b1101, 4'b1101};
      4'h8:    info = {4'b1101, 4'b1011};
      4'h3:    info = {4'b1011, 4'b1110};
      4'h6:    info = {4'b1011, 4'b1101};
      4'h9:    info = {4'b1011, 4'b1011};
      4'hE:    info = {4'b1011, 4'b0111};
      4'hA:    info = {4'b0111, 4'b1110};
      4'hC:    info = {4'b0111, 4'b1011};
      default: info = 8'hFF;
    endcase
    return info;
  endfunction

  assign in_info   = key_lookup(in_digit);
  assign key_info  = key_lookup(key_q);
  assign in_mapped = (in_info[7:4] != 4'hF);

  assign in_ready  = (count_q < FIFO_FULL);
  assign busy      = (count_q != '0) || (state_q != IDLE);
  assign pressed   = (state_q == PRESS);
  assign done      = done_q;
  assign bad_code  = bad_code_q;

  // Row responds to the column in the same cycle so the decoder sees a coherent pair.
  assign row = (!reset && (state_q == PRESS) && (column == key_info[7:4])) ? key_info[3:0] : 4'hF;

  always_comb begin
    push       = in_valid && in_ready;
    push_store = push && in_mapped;
    pop        = (state_q == IDLE) && (count_q != '0);
    frame_end  = (column == 4'hF) && (col_prev_q != 4'hF);

    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    col_prev_d = column;
    done_d     = 1'b0;
    bad_code_d = push && !in_mapped;

    if (push_store) begin
      mem_d[wr_ptr_q] = in_digit;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      key_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_store && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_store) begin
      count_d = count_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ARM;
        end
      end
      ARM: begin
        if (frame_end) begin
          state_d = PRESS;
          cnt_d   = '0;
        end
      end
      PRESS: begin
        if (frame_end) begin
          if (cnt_q == PRESS_LAST) begin
            cnt_d   = '0;
            state_d = RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        if (frame_end) begin
          if (cnt_q == RELEASE_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      col_prev_q <= 4'hF;
      done_q     <= 1'b0;
      bad_code_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      col_prev_q <= col_prev_d;
      done_q     <= done_d;
      bad_code_q <= bad_code_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: a 5-cycle column scanner and a small decoder
// model turn row activity into emitted digits, press lengths and release gaps.
module tb_keypad_emulator;

  logic       clk;
  logic       reset;
  logic [3:0] column;
  logic [3:0] row;
  logic [3:0] in_digit;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       pressed;
  logic       bad_code;
  logic       done;

  int vectors;
  int miscompares;

  logic       scan_en;
  logic [3:0] scan_seq [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hF};

  logic [3:0] emitted [$];
  int         runs [$];
  int         gaps [$];
  int         done_cnt;
  int         bad_cnt;
  int         pressed_total;
  int         row_low_total;
  int         bad_row;
  int         seen_any;

  keypad_emulator #(.DEPTH(4), .PRESS_FRAMES(2), .RELEASE_FRAMES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .column   (column),
    .row      (row),
    .in_digit (in_digit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .pressed  (pressed),
    .bad_code (bad_code),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Column scanner; holding scan_en low parks the strobe at idle.
  initial begin
    int phase;
    phase  = 0;
    column = 4'hF;
    forever begin
      @(posedge clk);
      #1;
      if (scan_en) begin
        column = scan_seq[phase];
        phase  = (phase == 4) ? 0 : phase + 1;
      end else begin
        column = 4'hF;
      end
    end
  end

  function automatic logic [4:0] decode(input logic [3:0] c, input logic [3:0] r);
    logic [4:0] res;
    case ({c, r})
      8'hEE: res = {1'b1, 4'h1};
      8'hED: res = {1'b1, 4'h4};
      8'hEB: res = {1'b1, 4'h7};
      8'hE7: res = {1'b1, 4'h0};
      8'hDE: res = {1'b1, 4'h2};
      8'hDD: res = {1'b1, 4'h5};
      8'hDB: res = {1'b1, 4'h8};
      8'hBE: res = {1'b1, 4'h3};
      8'hBD: res = {1'b1, 4'h6};
      8'hBB: res = {1'b1, 4'h9};
      8'hB7: res = {1'b1, 4'hE};
      8'h7E: res = {1'b1, 4'hA};
      8'h7B: res = {1'b1, 4'hC};
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  // Decoder model: a digit is emitted at the end of the first frame that shows a key.
  initial begin
    logic [3:0] prev_col;
    logic       frame_has;
    logic       prev_has;
    logic [3:0] frame_key;
    logic [4:0] dec;
    int         run_len;
    int         gap_len;
    prev_col  = 4'hF;
    frame_has = 1'b0;
    prev_has  = 1'b0;
    frame_key = 4'h0;
    run_len   = 0;
    gap_len   = 0;
    forever begin
      @(negedge clk);
      if (row != 4'hF) begin
        row_low_total++;
        dec = decode(column, row);
        if (!dec[4]) begin
          bad_row++;
        end else begin
          frame_has = 1'b1;
          frame_key = dec[3:0];
        end
      end
      if (pressed)  pressed_total++;
      if (done)     done_cnt++;
      if (bad_code) bad_cnt++;
      if (column == 4'hF && prev_col != 4'hF) begin
        if (frame_has) begin
          if (!prev_has) begin
            emitted.push_back(frame_key);
            if (seen_any != 0) gaps.push_back(gap_len);
            seen_any = 1;
            run_len  = 1;
          end else begin
            run_len++;
          end
        end else begin
          if (prev_has) begin
            runs.push_back(run_len);
            gap_len = 1;
          end else begin
            gap_len++;
          end
        end
        prev_has  = frame_has;
        frame_has = 1'b0;
      end
      prev_col = column;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, output int stalls);
    stalls = 0;
    @(posedge clk);
    #1;
    in_digit = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && stalls < 400) begin
      stalls++;
      @(negedge clk);
    end
    checkOutput("push_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      n++;
      @(negedge clk);
    end
    checkOutput({"idle_", tag}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_pressed(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!pressed && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput({"press_wait_", tag}, {31'd0, pressed}, 32'd1);
  endtask

  task automatic clear_monitor();
    emitted.delete();
    runs.delete();
    gaps.delete();
    done_cnt      = 0;
    bad_cnt       = 0;
    pressed_total = 0;
    row_low_total = 0;
    seen_any      = 0;
  endtask

  initial begin
    int stalls;
    int snap_emit;
    int snap_press;
    int n;
    vectors     = 0;
    miscompares = 0;
    bad_row     = 0;
    scan_en     = 1'b1;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_digit    = 4'h0;
    clear_monitor();

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_row", {28'd0, row}, 32'hF);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_pressed", {31'd0, pressed}, 32'd0);
    checkOutput("reset_bad_code", {31'd0, bad_code}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    repeat (10) @(negedge clk);
    clear_monitor();

    // Single digit 5
    applyStimulus(4'h5, stalls);
    @(negedge clk);
    checkOutput("single_busy_after_push", {31'd0, busy}, 32'd1);
    checkOutput("single_not_pressed_yet", {31'd0, pressed}, 32'd0);
    wait_idle("single", 200);
    checkOutput("single_emit_count", emitted.size(), 32'd1);
    checkOutput("single_emit_digit", {28'd0, emitted[0]}, 32'h5);
    checkOutput("single_press_frames", runs[0], 32'd2);
    checkOutput("single_pressed_cycles", pressed_total, 32'd10);
    checkOutput("single_row_low_cycles", row_low_total, 32'd2);
    checkOutput("single_done_count", done_cnt, 32'd1);
    clear_monitor();

    // Repeated digit 1, 1
    applyStimulus(4'h1, stalls);
    applyStimulus(4'h1, stalls);
    wait_idle("repeat", 300);
    checkOutput("repeat_emit_count", emitted.size(), 32'd2);
    checkOutput("repeat_emit_first", {28'd0, emitted[0]}, 32'h1);
    checkOutput("repeat_emit_second", {28'd0, emitted[1]}, 32'h1);
    checkOutput("repeat_gap_frames", gaps[0], 32'd3);
    checkOutput("repeat_second_press_frames", runs[1], 32'd2);
    checkOutput("repeat_done_count", done_cnt, 32'd2);
    clear_monitor();

    // FIFO full: digit 8 in flight, then 1,2,3,4 fill the FIFO and 6 must stall
    applyStimulus(4'h8, stalls);
    wait_pressed("full");
    applyStimulus(4'h1, stalls);
    applyStimulus(4'h2, stalls);
    applyStimulus(4'h3, stalls);
    applyStimulus(4'h4, stalls);
    @(negedge clk);
    checkOutput("full_in_ready_low", {31'd0, in_ready}, 32'd0);
    checkOutput("full_busy", {31'd0, busy}, 32'd1);
    applyStimulus(4'h6, stalls);
    checkOutput("full_fifth_push_stalled", {31'd0, (stalls > 0)}, 32'd1);
    wait_idle("full", 800);
    checkOutput("full_emit_count", emitted.size(), 32'd6);
    checkOutput("full_order_0", {28'd0, emitted[0]}, 32'h8);
    checkOutput("full_order_1", {28'd0, emitted[1]}, 32'h1);
    checkOutput("full_order_2", {28'd0, emitted[2]}, 32'h2);
    checkOutput("full_order_3", {28'd0, emitted[3]}, 32'h3);
    checkOutput("full_order_4", {28'd0, emitted[4]}, 32'h4);
    checkOutput("full_order_5", {28'd0, emitted[5]}, 32'h6);
    checkOutput("full_done_count", done_cnt, 32'd6);
    clear_monitor();

    // Bad code 11 then 14
    applyStimulus(4'hB, stalls);
    @(negedge clk);
    checkOutput("bad_code_pulse", {31'd0, bad_code}, 32'd1);
    checkOutput("bad_code_not_stored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("bad_code_one_cycle", {31'd0, bad_code}, 32'd0);
    applyStimulus(4'hE, stalls);
    wait_idle("bad", 200);
    checkOutput("bad_emit_count", emitted.size(), 32'd1);
    checkOutput("bad_emit_digit", {28'd0, emitted[0]}, 32'hE);
    checkOutput("bad_pulse_count", bad_cnt, 32'd1);
    checkOutput("bad_pressed_cycles", pressed_total, 32'd10);
    clear_monitor();

    // Reset while 9 is pressed with two digits queued
    applyStimulus(4'h9, stalls);
    wait_pressed("reset");
    applyStimulus(4'h1, stalls);
    applyStimulus(4'h2, stalls);
    n = 0;
    @(posedge clk);
    #2;
    while (!(pressed && column == 4'hB) && n < 50) begin
      n++;
      @(posedge clk);
      #2;
    end
    checkOutput("reset_mid_on_key_column", {31'd0, (pressed && column == 4'hB)}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_row", {28'd0, row}, 32'hF);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_mid_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_mid_pressed", {31'd0, pressed}, 32'd0);
    snap_emit  = emitted.size();
    snap_press = pressed_total;
    repeat (60) @(negedge clk);
    checkOutput("reset_mid_no_new_digit", emitted.size(), snap_emit);
    checkOutput("reset_mid_no_press", pressed_total, snap_press);
    checkOutput("reset_mid_no_done", done_cnt, 32'd0);
    clear_monitor();

    // Stalled scan: column parked at idle while 7 waits in ARM
    scan_en = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(4'h7, stalls);
    repeat (40) @(negedge clk);
    checkOutput("stall_not_pressed", {31'd0, pressed}, 32'd0);
    checkOutput("stall_row", {28'd0, row}, 32'hF);
    checkOutput("stall_busy", {31'd0, busy}, 32'd1);
    checkOutput("stall_no_press_cycles", pressed_total, 32'd0);
    scan_en = 1'b1;
    wait_idle("stall", 200);
    checkOutput("stall_emit_count", emitted.size(), 32'd1);
    checkOutput("stall_emit_digit", {28'd0, emitted[0]}, 32'h7);

    checkOutput("row_never_unmapped", bad_row, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
